// File: rtl/delay_pkg.sv
// Shared helpers for prog_delay_line: delay-setting width derivation and saturation.
package delay_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A requested delay of 0 means "as short as possible"; oversize requests pin to the line length.
  function automatic int sat_delay(input int req, input int max_delay);
    if (req == 0) return 1;
    if (req > max_delay) return max_delay;
    return req;
  endfunction

endpackage

// File: rtl/delay_lane.sv
// One lane: MAX_DELAY-stage {valid,data} shift register tapped at stage cur_delay-1.
// Output is cur_delay cycles after input, straight from stage flops; no backpressure.
module delay_lane
  import delay_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 16,
  parameter int DW        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic [DW-1:0]    cur_delay,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  logic [MAX_DELAY-1:0] r_vld;
  logic [WIDTH-1:0]     r_dat [MAX_DELAY];
  logic [MAX_DELAY-1:0] w_in_range;
  logic [DW-1:0]        w_tap;

  assign w_tap = cur_delay - 1'b1;

  always_comb begin
    w_in_range = '0;
    for (int k = 0; k < MAX_DELAY; k++) w_in_range[k] = (k < int'(cur_delay));
  end

  // Valid bits are not carried past the tap, so raising the delay later cannot release stale samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      for (int k = 0; k < MAX_DELAY; k++) r_dat[k] <= '0;
    end else begin
      r_vld[0] <= in_valid & ~flush;
      r_dat[0] <= in_data;
      for (int k = 1; k < MAX_DELAY; k++) begin
        r_vld[k] <= r_vld[k-1] & w_in_range[k] & ~flush;
        r_dat[k] <= r_dat[k-1];
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (k == int'(w_tap)) begin
        out_valid = r_vld[k];
        out_data  = r_dat[k];
      end
    end
  end

  assign busy = |(r_vld & w_in_range);

endmodule

// File: rtl/prog_delay_line.sv
// Multi-lane delay line with run-time delay 1..MAX_DELAY, flush and guarded reconfiguration.
// Latency cur_delay cycles, one sample per lane per cycle, no backpressure.
module prog_delay_line
  import delay_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int CHANNELS  = 2,
  parameter  int MAX_DELAY = 16,
  localparam int DW        = clog2(MAX_DELAY + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [DW-1:0]             cfg_delay,
  input  logic                      cfg_load,
  input  logic                      flush,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [DW-1:0]             cur_delay,
  output logic                      busy,
  output logic                      cfg_err
);

  logic [DW-1:0]       r_cur_delay;
  logic                r_cfg_err;
  logic [CHANNELS-1:0] w_lane_busy;
  logic                w_busy;
  logic                w_accept;
  logic [DW-1:0]       w_sat_delay;

  assign w_busy      = |w_lane_busy;
  // Changing the delay with samples in flight would misalign them, so only an idle line reconfigures.
  assign w_accept    = cfg_load & ~w_busy & ~flush;
  assign w_sat_delay = DW'(sat_delay(int'(cfg_delay), MAX_DELAY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_delay <= DW'(MAX_DELAY);
      r_cfg_err   <= 1'b0;
    end else begin
      if (w_accept) r_cur_delay <= w_sat_delay;
      r_cfg_err <= cfg_load & ~w_accept;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    delay_lane #(
      .WIDTH     (WIDTH),
      .MAX_DELAY (MAX_DELAY),
      .DW        (DW)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_data   (in_data[g*WIDTH +: WIDTH]),
      .flush     (flush),
      .cur_delay (r_cur_delay),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g*WIDTH +: WIDTH]),
      .busy      (w_lane_busy[g])
    );
  end

  assign cur_delay = r_cur_delay;
  assign busy      = w_busy;
  assign cfg_err   = r_cfg_err;

endmodule

// File: doc/prog_delay_line.md
# prog_delay_line

Parametrised, synthesisable multi-channel delay line with a run-time programmable delay of 1..MAX_DELAY clock cycles, replacing hand-written `#N` behavioural delays in registered datapaths. It sits between a producer and a consumer that need a fixed latency alignment and exposes the same valid-qualified data per channel on both sides. Flush and safe reconfiguration are built in.

## Interface

Parameters:
- WIDTH, 8: data bits per channel.
- CHANNELS, 2: number of independent lanes sharing one delay setting.
- MAX_DELAY, 16: maximum programmable delay in cycles (≥1).
- DW, clog2(MAX_DELAY+1): width of delay setting (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  CHANNELS  per-lane input qualifier.
- in_data  in  CHANNELS*WIDTH  lane i at [i*WIDTH +: WIDTH].
- cfg_delay  in  DW  requested delay.
- cfg_load  in  1  request to apply cfg_delay.
- flush  in  1  discard all in-flight samples.
- out_valid  out  CHANNELS  per-lane output qualifier.
- out_data  out  CHANNELS*WIDTH  delayed data, same packing.
- cur_delay  out  DW  active delay setting.
- busy  out  1  any valid sample in flight in any lane.
- cfg_err  out  1  one-cycle pulse: cfg_load rejected.

## Operation

- Each lane is a MAX_DELAY-stage shift register of {valid, data}; output taps stage cur_delay-1.
- Stage 0 loads {in_valid[i], in_data[i]} every cycle; data captured regardless of valid, valid gates use.
- Effective delay: cfg_delay of 0 is stored as 1; values > MAX_DELAY are stored as MAX_DELAY. cur_delay shows the stored value.
- Reconfiguration: cfg_load accepted only when busy=0 and flush=0; cur_delay updates at that edge. Otherwise ignored, cur_delay unchanged, cfg_err=1 the next cycle.
- cfg_load and in_valid in the same cycle with busy=0: new delay accepted, sample enters stage 0 and emerges at the new delay.
- flush: at the edge it is sampled, all stage valid bits clear; inputs presented that cycle are dropped (flush wins). Data bits unaffected.
- busy = OR of valid bits in stages 0..cur_delay-1 of all lanes; stages beyond the tap are ignored.
- Lanes are independent; no cross-lane ordering except the shared delay.

## Timing

- Reset (async assert, sync-safe deassert by system): all stage valid/data = 0, out_valid=0, out_data=0, cur_delay=MAX_DELAY, busy=0, cfg_err=0.
- Latency: sample presented in cycle n appears on out_valid/out_data in cycle n+cur_delay. Throughput one sample per lane per cycle.
- out_* are registered outputs (stage flops); no combinational path input→output.
- cfg_err is registered; high exactly one cycle per rejected cfg_load cycle.
- Reset mid-stream: all in-flight samples lost immediately; no output after reset release until new input plus delay.
- flush with sample at tap in same cycle: that output still shows in the flush cycle; out_valid=0 from the next cycle.

## Structure

- Shared package/header `delay_pkg`: clog2 function, DW derivation, delay saturation function (0→1, >MAX→MAX).
- Sub-module `delay_lane` (one lane: shift register, tap mux, lane-busy OR); top instantiates CHANNELS copies via generate and holds cur_delay, cfg logic, cfg_err and busy reduction.

## Test plan

- Reset then cfg_delay=4, cfg_load=1: cur_delay=4; lane0 in_valid=1, data 0xA5 in cycle 10 → out_valid[0]=1, out_data lane0=0xA5 in cycle 14 only.
- Back-to-back stream 0x01..0x08 on both lanes, delay 3 → identical sequence out starting 3 cycles later, no gaps; busy falls 3 cycles after last input.
- cfg_load with cfg_delay=7 while busy=1 → cfg_err pulses one cycle, cur_delay unchanged; repeat after drain → accepted, cur_delay=7.
- cfg_delay=0 → cur_delay=1, one-cycle latency; cfg_delay=31 (MAX 16) → cur_delay=16.
- Flush with 3 samples in flight plus in_valid=1 same cycle → no out_valid afterwards, busy=0 next cycle.
- Assert reset mid-stream at delay 5 → outputs 0 immediately, cur_delay=16, no stale output after release.
